// File: rtl/temp_sample_ctrl.sv
// Scheduled ADC conversion sequencer: periodic starts, per-conversion timeout,
// 4-sample moving average and an over-temperature alarm with hysteresis.
module temp_sample_ctrl #(
  parameter int SAMPLE_PERIOD = 50000,
  parameter int TIMEOUT       = 1000,
  parameter int ALARM_CODE    = 3643,
  parameter int HYST          = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        err_clr,
  output logic        adc_start,
  input  logic        adc_eoc,
  input  logic [11:0] adc_data,
  output logic [11:0] temp_avg,
  output logic        avg_valid,
  output logic        alarm,
  output logic        timeout_err,
  output logic [6:0]  seven_seg
);

  localparam int PW = $clog2(SAMPLE_PERIOD);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [PW-1:0] PERIOD_LAST = PW'(SAMPLE_PERIOD - 1);
  localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT - 1);
  localparam logic [12:0]   SET_LVL     = 13'(ALARM_CODE);
  localparam logic [12:0]   CLR_LVL     = 13'(ALARM_CODE + HYST);

  typedef enum logic [2:0] {IDLE, START, CONVERT, UPDATE, WAIT} state_t;

  state_t        state, state_next;
  logic [PW-1:0] period_cnt;
  logic [TW-1:0] to_cnt;
  logic          timeout_hit;
  logic [11:0]   sample;
  logic [11:0]   sbuf [4];
  logic [1:0]    wr_ptr;
  logic [2:0]    fill, fill_next;
  logic [13:0]   sum, sum_next;
  logic [11:0]   evicted;
  logic          alarm_next;

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_next  = state;
    adc_start   = 1'b0;
    timeout_hit = 1'b0;
    unique case (state)
      IDLE:    if (enable) state_next = START;
      START: begin
        adc_start  = 1'b1;
        state_next = CONVERT;
      end
      CONVERT: begin
        if (adc_eoc) begin
          state_next = UPDATE;
        end else if (to_cnt == TO_LAST) begin
          timeout_hit = 1'b1;
          state_next  = WAIT;
        end
      end
      UPDATE:  state_next = WAIT;
      WAIT: begin
        if (!enable)                     state_next = IDLE;
        else if (period_cnt == PERIOD_LAST) state_next = START;
      end
      default: state_next = IDLE;
    endcase
  end

  // Moving-average update; the evicted slot only counts once the buffer is full.
  always_comb begin
    evicted    = (fill == 3'd4) ? sbuf[wr_ptr] : 12'd0;
    sum_next   = sum - {2'b00, evicted} + {2'b00, sample};
    fill_next  = (fill == 3'd4) ? 3'd4 : fill + 3'd1;
    alarm_next = alarm;
    if ({1'b0, sum_next[13:2]} <= SET_LVL)     alarm_next = 1'b1;
    else if ({1'b0, sum_next[13:2]} > CLR_LVL) alarm_next = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      period_cnt  <= '0;
      to_cnt      <= '0;
      sample      <= '0;
      wr_ptr      <= '0;
      fill        <= '0;
      sum         <= '0;
      temp_avg    <= '0;
      avg_valid   <= 1'b0;
      alarm       <= 1'b0;
      timeout_err <= 1'b0;
      // NOTE: the sample buffer is cleared too; it is only four words and a
      // defined reset state keeps the running sum consistent with its contents.
      for (int i = 0; i < 4; i++) sbuf[i] <= '0;
    end else begin
      state     <= state_next;
      avg_valid <= 1'b0;

      if (state_next == START)  period_cnt <= '0;
      else if (state != IDLE)   period_cnt <= period_cnt + 1'b1;

      unique case (state)
        START:   to_cnt <= '0;
        CONVERT: begin
          if (adc_eoc) sample <= adc_data;
          else         to_cnt <= to_cnt + 1'b1;
        end
        UPDATE: begin
          sbuf[wr_ptr] <= sample;
          wr_ptr       <= wr_ptr + 2'd1;
          fill         <= fill_next;
          sum          <= sum_next;
          if (fill_next == 3'd4) begin
            temp_avg  <= sum_next[13:2];
            avg_valid <= 1'b1;
            alarm     <= alarm_next;
          end
        end
        default: ;
      endcase

      // A timeout in the same cycle as a clear keeps the flag set.
      if (timeout_hit)  timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
    end
  end

  assign seven_seg = alarm ? 7'b1001001 : 7'b1111111;

endmodule
